// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, FSM encodings, owner codes and the latched memory command
// for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline ports (instruction + data) and the unified memory handshake.
// slave is the arbiter's view, master is the pipeline/memory environment's view.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_valid;
    logic          i_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_stall;

    logic          bus_err;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall, bus_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
        input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall, bus_err,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Per-transaction wait timer: cleared on grant, counts while enabled, saturates at TIMEOUT.
// hit_c_o flags the enabled cycle in which the count reaches TIMEOUT; TIMEOUT=0 never hits.
module arb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_c_o
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q < CW'(TIMEOUT))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_c_o = (TIMEOUT != 0) && en_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch port and the data port.
// Data has fixed priority; one transaction in flight; results pulse *_valid for one cycle.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    logic [1:0]    state_q, state_d;
    logic          own_q, own_d;
    mem_cmd_t      cmd_q, cmd_d;
    logic          mem_req_q, mem_req_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_valid_q, i_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          bus_err_q, bus_err_d;

    logic          grant_c;
    logic          busy_c;
    logic          hit_c;
    logic          owner_req_c;
    logic [DW-1:0] rdata_c;

    assign busy_c = (state_q == ST_BUSY);

    arb_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (grant_c),
        .en_i    (busy_c),
        .hit_c_o (hit_c)
    );

    // Next-state and registered-output logic; a result is dropped if its requester let go.
    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        cmd_d       = cmd_q;
        mem_req_d   = mem_req_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_valid_d   = 1'b0;
        d_valid_d   = 1'b0;
        bus_err_d   = 1'b0;
        grant_c     = 1'b0;
        owner_req_c = (own_q == OWN_D) ? bus.d_req : bus.i_req;
        rdata_c     = bus.mem_ack ? bus.mem_rdata : '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.d_req) begin
                    grant_c     = 1'b1;
                    own_d       = OWN_D;
                    cmd_d.we    = bus.d_we;
                    cmd_d.addr  = bus.d_addr;
                    cmd_d.wdata = bus.d_wdata;
                    cmd_d.be    = bus.d_we ? bus.d_be : '0;
                end else if (bus.i_req) begin
                    grant_c     = 1'b1;
                    own_d       = OWN_I;
                    cmd_d       = '0;
                    cmd_d.addr  = bus.i_addr;
                end
                if (grant_c) begin
                    mem_req_d = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // An ack in the same cycle as the timeout still completes normally.
                if (bus.mem_ack || hit_c) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                    bus_err_d = ~bus.mem_ack & owner_req_c;
                    if (own_q == OWN_D) begin
                        d_rdata_d = rdata_c;
                        d_valid_d = owner_req_c;
                    end else begin
                        i_rdata_d = rdata_c;
                        i_valid_d = owner_req_c;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            own_q     <= OWN_I;
            cmd_q     <= '0;
            mem_req_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            cmd_q     <= cmd_d;
            mem_req_q <= mem_req_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.mem_be    = cmd_q.be;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_valid   = i_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.bus_err   = bus_err_q;

    // Stalls follow the live request so the hazard unit sees them even during reset.
    assign bus.i_stall   = bus.i_req & ~i_valid_q;
    assign bus.d_stall   = bus.d_req & ~d_valid_q;

endmodule
